// File: rtl/hpu_pkg.sv
// ============================================================================
// Module : hpu_pkg
// Brief  : Shared types and constants for the hypervector majority sequencer.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package hpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACCUM   = 3'd2,
        S_TIE     = 3'd3,
        S_DRAIN   = 3'd4,
        S_CAPTURE = 3'd5,
        S_OUT     = 3'd6
    } state_t;

    typedef logic [29:0] count_t;

    // Primitive polynomial x^1024 + x^1015 + x^1002 + x^1001 + 1 (bit n-1 holds tap n).
    localparam logic [1023:0] c_LFSR_TAPS_1024 = (1024'(1) << 1023) | (1024'(1) << 1014)
                                               | (1024'(1) << 1001) | (1024'(1) << 1000);

    function automatic logic [1023:0] lfsr_taps(input int width);
        logic [1023:0] t;
        t = '0;
        case (width)
            8:       begin t[7] = 1'b1;  t[5] = 1'b1;  t[4] = 1'b1;  t[3] = 1'b1;  end
            16:      begin t[15] = 1'b1; t[14] = 1'b1; t[12] = 1'b1; t[3] = 1'b1;  end
            32:      begin t[31] = 1'b1; t[21] = 1'b1; t[1] = 1'b1;  t[0] = 1'b1;  end
            64:      begin t[63] = 1'b1; t[62] = 1'b1; t[60] = 1'b1; t[59] = 1'b1; end
            default: t = c_LFSR_TAPS_1024;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hv_lfsr.sv
// ============================================================================
// Module : hv_lfsr
// Brief  : Fibonacci LFSR producing the tie-break hypervector; advances on step.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hv_lfsr
    import hpu_pkg::*;
#(
    parameter int               WIDTH = 1024,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    localparam logic [1023:0]      c_TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0]   c_TAPS      = c_TAPS_FULL[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (step) begin
            q <= {q[WIDTH-2:0], ^(q & c_TAPS)};
        end
    end

endmodule

`default_nettype wire

// File: rtl/majority_seq.sv
// ============================================================================
// Module : majority_seq
// Brief  : Job sequencer driving the bundling counter array and result handshake.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module majority_seq
    import hpu_pkg::*;
#(
    parameter int             DIM      = 1023,
    parameter int             SIGN_LAT = 2,
    parameter logic [DIM:0]   SEED     = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  count_t       num_hv,
    input  logic         core_valid,
    output logic         core_ready,
    output logic         clr,
    output logic         store,
    output logic         tmp_even,
    output logic [DIM:0] tmp_rand,
    output logic         stream_v,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int       c_WAIT_W    = (SIGN_LAT > 1) ? $clog2(SIGN_LAT) : 1;
    localparam int       c_WAIT_INIT_I = (SIGN_LAT > 0) ? SIGN_LAT - 1 : 0;
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(c_WAIT_INIT_I);
    // With no sign latency the last counter update goes straight to CAPTURE.
    localparam logic     c_SKIP_DRAIN = (SIGN_LAT == 0);
    localparam state_t   c_POST_UPD   = c_SKIP_DRAIN ? S_CAPTURE : S_DRAIN;

    state_t              r_state;
    count_t              r_num_hv;
    count_t              r_remaining;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_accept;

    assign core_ready = (r_state == S_ACCUM);
    assign store      = core_ready & core_valid;
    assign w_accept   = (r_state == S_IDLE) & start & (num_hv != '0);

    hv_lfsr #(
        .WIDTH (DIM + 1),
        .SEED  (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (w_accept),
        .q     (tmp_rand)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_num_hv    <= '0;
            r_remaining <= '0;
            r_wait      <= '0;
            clr         <= 1'b0;
            tmp_even    <= 1'b0;
            stream_v    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            clr      <= 1'b0;
            tmp_even <= 1'b0;
            stream_v <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (num_hv != '0) begin
                            r_num_hv <= num_hv;
                            r_state  <= S_CLEAR;
                            clr      <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_remaining <= r_num_hv;
                    r_state     <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (core_valid) begin
                        r_remaining <= r_remaining - count_t'(1);
                        if (r_remaining == count_t'(1)) begin
                            // An even vote count needs one random vote to break ties.
                            if (!r_num_hv[0]) begin
                                r_state  <= S_TIE;
                                tmp_even <= 1'b1;
                            end else begin
                                r_state  <= c_POST_UPD;
                                stream_v <= c_SKIP_DRAIN;
                                r_wait   <= c_WAIT_INIT;
                            end
                        end
                    end
                end
                S_TIE: begin
                    r_state  <= c_POST_UPD;
                    stream_v <= c_SKIP_DRAIN;
                    r_wait   <= c_WAIT_INIT;
                end
                S_DRAIN: begin
                    if (r_wait == '0) begin
                        r_state  <= S_CAPTURE;
                        stream_v <= 1'b1;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    r_state   <= S_OUT;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/majority_seq.md
MAJORITY_SEQ -- requirements
Module: majority_seq

Interface
REQ-001 SHALL have parameter DIM, default 1023, meaning the MSB index of the hypervector, so vectors are DIM+1 bits wide.
REQ-002 SHALL have parameter SIGN_LAT, default 2, meaning the number of cycles from the last counter update until sign_bit is valid.
REQ-003 SHALL have parameter SEED, default all-ones (DIM+1 bits), meaning the reset value of the tie-break LFSR.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: job request, sampled only in IDLE.
REQ-007 SHALL have port num_hv, input, 30 bits: number of core results in the job, sampled with start.
REQ-008 SHALL have ports core_valid (input, 1 bit) and core_ready (output, 1 bit): the core-result handshake.
REQ-009 SHALL have port clr, output, 1 bit: synchronous clear pulse to the counter array.
REQ-010 SHALL have port store, output, 1 bit: accumulate the current core result into the counters.
REQ-011 SHALL have port tmp_even, output, 1 bit: inject a tie-break vote.
REQ-012 SHALL have port tmp_rand, output, DIM+1 bits: tie-break vector.
REQ-013 SHALL have port stream_v, output, 1 bit: capture sign_bit into stream_d.
REQ-014 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake toward DMA.
REQ-015 SHALL have ports busy (output, 1 bit), done (output, 1 bit) and err (output, 1 bit): job status.

Function
REQ-016 SHALL implement the FSM states IDLE, CLEAR, ACCUM, TIE, DRAIN, CAPTURE and OUT.
REQ-017 IDLE: when start=1 and num_hv>0, SHALL latch num_hv, step the LFSR once, and go to CLEAR. When start=1 and num_hv=0, SHALL pulse err for 1 cycle and stay in IDLE.
REQ-018 CLEAR: SHALL assert clr for exactly 1 cycle, load remaining=num_hv, then go to ACCUM.
REQ-019 ACCUM: SHALL hold core_ready=1. In each cycle with core_valid&core_ready, SHALL assert store=1 combinationally and decrement remaining. The transfer that brings remaining to 0 SHALL exit to TIE if num_hv is even, else to DRAIN.
REQ-020 SHALL never assert store in a cycle without a transfer, and SHALL never assert core_ready outside ACCUM.
REQ-021 TIE: SHALL assert tmp_even=1, store=0 for exactly 1 cycle, with tmp_rand stable, then go to DRAIN.
REQ-022 DRAIN: SHALL wait SIGN_LAT cycles (a SIGN_LAT of 0 means 0 wait cycles), then go to CAPTURE.
REQ-023 CAPTURE: SHALL assert stream_v for exactly 1 cycle, then go to OUT.
REQ-024 OUT: SHALL assert out_valid from the cycle after stream_v, holding it until out_ready=1. On that handshake, SHALL pulse done for 1 cycle and return to IDLE.
REQ-025 out_valid SHALL NOT drop before out_ready is seen.
REQ-026 busy SHALL equal 1 in every state except IDLE.
REQ-027 start while busy SHALL be ignored, with no error.
REQ-028 tmp_rand SHALL be a (DIM+1)-bit maximal-length Fibonacci LFSR stepped once per accepted start and constant at all other times.
REQ-029 remaining SHALL be 30 bits wide; num_hv=2^30-1 SHALL complete without wrap.
REQ-030 clr, store, tmp_even and stream_v SHALL be mutually exclusive in every cycle.

Reset
REQ-031 Asserting rst (rst=0) SHALL immediately force IDLE, with remaining=0 and tmp_rand=SEED.
REQ-032 During reset, all 1-bit outputs SHALL be 0.
REQ-033 Reset mid-job SHALL abandon the job with no done pulse. The next job SHALL still begin with clr, so the counters need no separate reset.

Structure
REQ-034 A shared package hpu_pkg SHALL hold the state enum, the 30-bit count type, and the LFSR tap constant.
REQ-035 The LFSR SHALL be a sub-module named hv_lfsr, with ports clk, rst, step and q.
REQ-036 The implementation SHALL be 120-400 lines of RTL, with registered outputs except store and core_ready.

Verification
REQ-037 Odd job: num_hv=3, core_valid held high. Required: clr once, store on 3 consecutive cycles, tmp_even never, stream_v exactly SIGN_LAT+1 cycles after the last store, done after out_ready.
REQ-038 Even job: num_hv=2. Required: 2 store pulses, then a 1-cycle tmp_even with tmp_rand equal to the first LFSR step of SEED, then stream_v.
REQ-039 Backpressure: core_valid toggled 1,0,1,0 and out_ready held 0 for 5 cycles. Required: store only on valid cycles, out_valid stable for 5 cycles, done exactly once.
REQ-040 num_hv=0 start. Required: err pulses 1 cycle, busy stays 0, clr/store never asserted. A start during ACCUM is ignored.
REQ-041 Reset asserted mid-ACCUM after 1 of 4 stores. Required: all outputs 0 immediately, tmp_rand=SEED. A new num_hv=1 job then completes normally, starting with clr.
